// File: rtl/moxie_wb_arbiter.sv
// moxie_wb_arbiter: two-master Wishbone arbiter between the Moxie fetch port (f_*)
// and load/store port (d_*) and a single external Wishbone master bus (wb_*).
//
// Data has priority. A saturating starvation counter hands the bus to fetch once
// STARVE_LIMIT data grants have been issued while fetch was waiting. A grant is held
// until its owner drops cyc. The bus is re-arbitrated on that same edge, so a handover
// takes no idle cycle. Ack and err are routed only to the granted master.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   f_cyc_i/f_stb_i/f_adr_i  fetch request (read-only); f_dat_o/f_ack_o/f_err_o response
//   d_cyc_i/d_stb_i/d_we_i/d_sel_i/d_adr_i/d_dat_i  data request
//   d_dat_o/d_ack_o/d_err_o  data response
//   wb_*_o                   external bus request; wb_dat_i/wb_ack_i/wb_err_i response
//   grant_o                  one-hot grant: 01 fetch, 10 data, 00 none
//
// Build option: define MOXIE_ARB_WATCHDOG_EN to add a bus watchdog. It aborts a cycle
// that sees no ack/err for TIMEOUT strobe cycles by pulsing err to the owner.

module moxie_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // Fetch port
  input  logic        f_cyc_i,
  input  logic        f_stb_i,
  input  logic [31:0] f_adr_i,
  output logic [31:0] f_dat_o,
  output logic        f_ack_o,
  output logic        f_err_o,
  // Data port
  input  logic        d_cyc_i,
  input  logic        d_stb_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_adr_i,
  input  logic [31:0] d_dat_i,
  output logic [31:0] d_dat_o,
  output logic        d_ack_o,
  output logic        d_err_o,
  // External bus
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntF = 2'd1,
    StGntD = 2'd2
  } state_e;

  state_e     r_state;
  logic [1:0] r_grant;
  logic [3:0] r_starve_cnt;

  logic w_gnt_f;
  logic w_gnt_d;
  logic w_f_req;
  logic w_d_req;
  logic w_timeout;
  logic w_arb;
  logic w_starve_ok;
  logic w_pick_d;
  logic w_pick_f;

  assign w_gnt_f = r_grant[0];
  assign w_gnt_d = r_grant[1];

`ifdef MOXIE_ARB_WATCHDOG_EN
  logic [7:0] r_wdt;
  logic       r_blk_f;
  logic       r_blk_d;
  logic       w_stb_raw;
  logic       w_new_grant;

  // An aborted master stays out of arbitration until it drops cyc.
  assign w_f_req   = f_cyc_i & ~r_blk_f;
  assign w_d_req   = d_cyc_i & ~r_blk_d;
  assign w_stb_raw = (w_gnt_f & f_cyc_i & f_stb_i) | (w_gnt_d & d_cyc_i & d_stb_i);
  // r_wdt counts completed silent strobe cycles, so the abort lands in strobe
  // cycle number TIMEOUT.
  assign w_timeout = w_stb_raw & ~wb_ack_i & ~wb_err_i & (r_wdt == 8'(TIMEOUT - 1));
  assign w_new_grant = w_arb & (w_pick_d | w_pick_f);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wdt   <= 8'd0;
      r_blk_f <= 1'b0;
      r_blk_d <= 1'b0;
    end else begin
      if (!f_cyc_i) r_blk_f <= 1'b0;
      if (!d_cyc_i) r_blk_d <= 1'b0;
      if (w_timeout) begin
        if (w_gnt_f) r_blk_f <= 1'b1;
        if (w_gnt_d) r_blk_d <= 1'b1;
        r_wdt <= 8'd0;
      end else if (w_new_grant || wb_ack_i || wb_err_i) begin
        r_wdt <= 8'd0;
      end else if (w_stb_raw) begin
        r_wdt <= r_wdt + 8'd1;
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_f_req          = f_cyc_i;
  assign w_d_req          = d_cyc_i;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT == 0);
`endif

  // Arbitrate from idle, or on the edge where the current owner has dropped cyc.
  assign w_arb = (r_state == StIdle) ||
                 ((r_state == StGntF) && !f_cyc_i) ||
                 ((r_state == StGntD) && !d_cyc_i);

  assign w_starve_ok = 32'(r_starve_cnt) < STARVE_LIMIT;
  assign w_pick_d    = w_d_req & (~w_f_req | w_starve_ok);
  assign w_pick_f    = ~w_pick_d & w_f_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= StIdle;
      r_grant      <= 2'b00;
      r_starve_cnt <= 4'd0;
    end else begin
      if ((r_state == StIdle) && !f_cyc_i) r_starve_cnt <= 4'd0;
      if (w_timeout) begin
        r_state <= StIdle;
        r_grant <= 2'b00;
      end else if (w_arb) begin
        if (w_pick_d) begin
          r_state <= StGntD;
          r_grant <= 2'b10;
          // Only data grants that make fetch wait count toward starvation.
          if (w_f_req && (r_starve_cnt != 4'hF)) r_starve_cnt <= r_starve_cnt + 4'd1;
        end else if (w_pick_f) begin
          r_state      <= StGntF;
          r_grant      <= 2'b01;
          r_starve_cnt <= 4'd0;
        end else begin
          r_state <= StIdle;
          r_grant <= 2'b00;
        end
      end
    end
  end

  // Bus mux driven from the registered grant; an abort kills cyc/stb in the same cycle.
  assign wb_cyc_o = ((w_gnt_f & f_cyc_i) | (w_gnt_d & d_cyc_i)) & ~w_timeout;
  assign wb_stb_o = ((w_gnt_f & f_stb_i) | (w_gnt_d & d_stb_i)) & ~w_timeout;
  assign wb_we_o  = w_gnt_d & d_we_i;
  assign wb_sel_o = w_gnt_d ? d_sel_i : (w_gnt_f ? 4'hF : 4'h0);
  assign wb_adr_o = w_gnt_d ? d_adr_i : (w_gnt_f ? f_adr_i : 32'd0);
  assign wb_dat_o = w_gnt_d ? d_dat_i : 32'd0;

  assign f_dat_o = wb_dat_i;
  assign d_dat_o = wb_dat_i;
  assign f_ack_o = w_gnt_f & wb_ack_i;
  assign d_ack_o = w_gnt_d & wb_ack_i;
  assign f_err_o = w_gnt_f & (wb_err_i | w_timeout);
  assign d_err_o = w_gnt_d & (wb_err_i | w_timeout);

  assign grant_o = r_grant;

endmodule

// File: tb/tb_moxie_wb_arbiter.sv
// Bench for moxie_wb_arbiter. A small slave model acks two cycles after a strobe is
// first seen; expected transactions go into a scoreboard queue when requested and are
// popped when the DUT produces the matching grant or ack.

module tb_moxie_wb_arbiter;

  localparam int unsigned StarveLimit = 4;
  localparam int unsigned Timeout     = 8;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_cyc, f_stb, d_cyc, d_stb, d_we;
  logic [3:0]  d_sel;
  logic [31:0] f_adr, d_adr, d_dat, rdata;
  logic        inj_ack, inj_err, slv_en, slv_ack;
  int          slv_cnt;
  logic [31:0] f_dat_o, d_dat_o, wb_adr_o, wb_dat_o;
  logic        f_ack_o, f_err_o, d_ack_o, d_err_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [1:0]  grant_o;

  exp_t sb_q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  moxie_wb_arbiter #(
    .STARVE_LIMIT (StarveLimit),
    .TIMEOUT      (Timeout)
  ) u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .f_cyc_i  (f_cyc),
    .f_stb_i  (f_stb),
    .f_adr_i  (f_adr),
    .f_dat_o  (f_dat_o),
    .f_ack_o  (f_ack_o),
    .f_err_o  (f_err_o),
    .d_cyc_i  (d_cyc),
    .d_stb_i  (d_stb),
    .d_we_i   (d_we),
    .d_sel_i  (d_sel),
    .d_adr_i  (d_adr),
    .d_dat_i  (d_dat),
    .d_dat_o  (d_dat_o),
    .d_ack_o  (d_ack_o),
    .d_err_o  (d_err_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_sel_o (wb_sel_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (rdata),
    .wb_ack_i (slv_ack | inj_ack),
    .wb_err_i (inj_err),
    .grant_o  (grant_o)
  );

  // Slave: ack two cycles after strobe is first seen, one-cycle ack pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slv_ack <= 1'b0;
      slv_cnt <= 0;
    end else begin
      slv_ack <= 1'b0;
      if (slv_en && wb_cyc_o && wb_stb_o && !slv_ack) begin
        if (slv_cnt == 1) begin
          slv_ack <= 1'b1;
          slv_cnt <= 0;
        end else begin
          slv_cnt <= slv_cnt + 1;
        end
      end else if (!(wb_cyc_o && wb_stb_o)) begin
        slv_cnt <= 0;
      end
    end
  end

  function automatic exp_t mk_exp(logic [1:0] g, logic [31:0] a, logic w, logic [3:0] s);
    exp_t t;
    t.gnt = g;
    t.adr = a;
    t.we  = w;
    t.sel = s;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; f_cyc = 0; f_stb = 0; f_adr = 0; d_cyc = 0; d_stb = 0; d_we = 0;
    d_sel = 0; d_adr = 0; d_dat = 0; inj_ack = 0; inj_err = 0; slv_en = 1;
    rdata = 32'hCAFE_0001;
    #12;
    n_vec++;
    if (grant_o !== 2'b00) begin
      n_err++; $display("FAIL reset_grant: got %b want 00", grant_o);
    end
    n_vec++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'd0 || wb_adr_o !== 32'd0) begin
      n_err++; $display("FAIL reset_bus: cyc/stb/we/sel %b adr %h want 0", 
                        {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, wb_adr_o);
    end
    n_vec++;
    if ({f_ack_o, f_err_o, d_ack_o, d_err_o} !== 4'b0000) begin
      n_err++; $display("FAIL reset_resp: got %b want 0000", {f_ack_o, f_err_o, d_ack_o, d_err_o});
    end
    n_vec++;
    if (f_dat_o !== 32'hCAFE_0001 || d_dat_o !== 32'hCAFE_0001) begin
      n_err++; $display("FAIL reset_rdata: f %h d %h want cafe0001", f_dat_o, d_dat_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    settle();
  endtask

  task automatic test_fetch_read();
    bit got = 0;
    bit dack = 0;
    int ack_c = -1;
    tick();
    f_adr = 32'h100; f_cyc = 1; f_stb = 1; rdata = 32'h1357_9BDF;
    sb_q.push_back(mk_exp(2'b01, 32'h100, 1'b0, 4'hF));
    @(negedge clk);
    n_vec++;
    if (grant_o !== 2'b00) begin
      n_err++; $display("FAIL fetch_latency: grant %b want 00 before edge", grant_o);
    end
    @(posedge clk);
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_vec++;
        if (grant_o !== 2'b01 || wb_cyc_o !== 1'b1) begin
          n_err++; $display("FAIL fetch_grant: grant %b cyc %b want 01 1", grant_o, wb_cyc_o);
        end
      end
      if (d_ack_o) dack = 1;
      if (wb_ack_i_obs()) begin
        got = 1; ack_c = c; e = sb_q.pop_front();
        n_vec++;
        if ({grant_o, wb_adr_o, wb_we_o, wb_sel_o} !== e) begin
          n_err++; $display("FAIL fetch_bus: got %b/%h/%b/%h want %b/%h/%b/%h", grant_o,
                            wb_adr_o, wb_we_o, wb_sel_o, e.gnt, e.adr, e.we, e.sel);
        end
        n_vec++;
        if (f_ack_o !== 1'b1 || f_dat_o !== 32'h1357_9BDF) begin
          n_err++; $display("FAIL fetch_ack: ack %b dat %h want 1 13579bdf", f_ack_o, f_dat_o);
        end
      end
      tick();
      if (got) begin f_cyc = 0; f_stb = 0; end
    end
    n_vec++;
    if (ack_c !== 2) begin
      n_err++; $display("FAIL fetch_ack_cycle: ack in cycle %0d want 2", ack_c);
    end
    n_vec++;
    if (dack !== 1'b0) begin
      n_err++; $display("FAIL fetch_no_dack: d_ack seen %b want 0", dack);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (grant_o !== 2'b00 || wb_cyc_o !== 1'b0) begin
      n_err++; $display("FAIL fetch_release: grant %b cyc %b want 00 0", grant_o, wb_cyc_o);
    end
    settle();
  endtask

  function automatic logic wb_ack_i_obs();
    return slv_ack | inj_ack;
  endfunction

  task automatic test_simultaneous();
    int done = 0;
    int gap = 0;
    logic [1:0] drop;
    tick();
    f_adr = 32'h200; f_cyc = 1; f_stb = 1;
    d_adr = 32'h300; d_we = 1; d_sel = 4'h3; d_dat = 32'h1234_5678; d_cyc = 1; d_stb = 1;
    sb_q.push_back(mk_exp(2'b10, 32'h300, 1'b1, 4'h3));
    sb_q.push_back(mk_exp(2'b01, 32'h200, 1'b0, 4'hF));
    @(posedge clk);
    for (int c = 0; c < 40 && done < 2; c++) begin
      @(negedge clk);
      drop = 2'b00;
      if (grant_o === 2'b00) gap++;
      if (wb_ack_i_obs()) begin
        done++;
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++; $display("FAIL simul_extra_ack: ack with empty scoreboard, grant %b", grant_o);
        end else begin
          e = sb_q.pop_front();
          drop = e.gnt;
          if ({grant_o, wb_adr_o, wb_we_o, wb_sel_o} !== e) begin
            n_err++; $display("FAIL simul_bus: got %b/%h/%b/%h want %b/%h/%b/%h", grant_o,
                              wb_adr_o, wb_we_o, wb_sel_o, e.gnt, e.adr, e.we, e.sel);
          end
          n_vec++;
          if ({d_ack_o, f_ack_o} !== e.gnt) begin
            n_err++; $display("FAIL simul_ack_route: d/f ack %b want %b", {d_ack_o, f_ack_o}, e.gnt);
          end
          n_vec++;
          if (wb_dat_o !== (e.gnt[1] ? 32'h1234_5678 : 32'd0)) begin
            n_err++; $display("FAIL simul_wdata: got %h for grant %b", wb_dat_o, e.gnt);
          end
        end
      end
      tick();
      if (drop[1]) begin d_cyc = 0; d_stb = 0; end
      if (drop[0]) begin f_cyc = 0; f_stb = 0; end
    end
    n_vec++;
    if (done !== 2) begin
      n_err++; $display("FAIL simul_timeout: %0d acks want 2", done);
    end
    n_vec++;
    if (gap !== 0) begin
      n_err++; $display("FAIL simul_gap: %0d idle cycles want 0", gap);
    end
    settle();
  endtask

  task automatic test_starvation();
    tick();
    d_we = 0; d_sel = 4'hC; f_adr = 32'h250;
    for (int k = 0; k < 6; k++) begin
      d_adr = 32'h400 + 32'(k);
      if (k == 4) sb_q.push_back(mk_exp(2'b01, f_adr, 1'b0, 4'hF));
      else        sb_q.push_back(mk_exp(2'b10, d_adr, 1'b0, 4'hC));
      f_cyc = 1; f_stb = 1; d_cyc = 1; d_stb = 1;
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      n_vec++;
      if ({grant_o, wb_adr_o, wb_we_o, wb_sel_o} !== e) begin
        n_err++; $display("FAIL starve_grant_%0d: got %b/%h/%b/%h want %b/%h/%b/%h", k, grant_o,
                          wb_adr_o, wb_we_o, wb_sel_o, e.gnt, e.adr, e.we, e.sel);
      end
      tick();
      f_cyc = 0; f_stb = 0; d_cyc = 0; d_stb = 0;
      tick();
    end
    settle();
  endtask

  task automatic test_fetch_burst();
    int done = 0;
    int fbeats = 0;
    logic [1:0] drop;
    tick();
    f_adr = 32'h500; f_cyc = 1; f_stb = 1;
    for (int i = 0; i < 3; i++) sb_q.push_back(mk_exp(2'b01, 32'h500, 1'b0, 4'hF));
    sb_q.push_back(mk_exp(2'b10, 32'h600, 1'b1, 4'hF));
    @(posedge clk);
    for (int c = 0; c < 60 && done < 4; c++) begin
      @(negedge clk);
      drop = 2'b00;
      if (fbeats < 3) begin
        n_vec++;
        if (grant_o !== 2'b01 || d_ack_o !== 1'b0) begin
          n_err++; $display("FAIL burst_hold_c%0d: grant %b d_ack %b want 01 0", c, grant_o, d_ack_o);
        end
      end
      if (wb_ack_i_obs() && sb_q.size() != 0) begin
        done++;
        e = sb_q.pop_front();
        n_vec++;
        if ({grant_o, wb_adr_o, wb_we_o, wb_sel_o} !== e) begin
          n_err++; $display("FAIL burst_bus: got %b/%h/%b/%h want %b/%h/%b/%h", grant_o,
                            wb_adr_o, wb_we_o, wb_sel_o, e.gnt, e.adr, e.we, e.sel);
        end
        if (e.gnt == 2'b01) fbeats++;
        if (e.gnt == 2'b10 || fbeats == 3) drop = e.gnt;
      end
      tick();
      if (c == 0) begin
        d_adr = 32'h600; d_we = 1; d_sel = 4'hF; d_cyc = 1; d_stb = 1;
      end
      if (drop[1]) begin d_cyc = 0; d_stb = 0; end
      if (drop[0]) begin f_cyc = 0; f_stb = 0; end
    end
    n_vec++;
    if (done !== 4) begin
      n_err++; $display("FAIL burst_timeout: %0d acks want 4", done);
    end
    settle();
  endtask

  task automatic test_stray();
    tick();
    inj_ack = 1; inj_err = 1;
    #1;
    n_vec++;
    if ({f_ack_o, f_err_o, d_ack_o, d_err_o} !== 4'b0000) begin
      n_err++; $display("FAIL stray_idle: f/d ack err %b want 0000", {f_ack_o, f_err_o, d_ack_o, d_err_o});
    end
    @(negedge clk);
    inj_ack = 0; inj_err = 0;
    n_vec++;
    if (grant_o !== 2'b00) begin
      n_err++; $display("FAIL stray_grant: grant %b want 00", grant_o);
    end
    tick();
    d_adr = 32'h650; d_we = 0; d_cyc = 1; d_stb = 1;
    @(posedge clk);
    @(negedge clk);
    inj_ack = 1; inj_err = 1;
    #1;
    n_vec++;
    if ({f_ack_o, f_err_o, d_ack_o, d_err_o} !== 4'b0011) begin
      n_err++; $display("FAIL stray_route: f/d ack err %b want 0011", {f_ack_o, f_err_o, d_ack_o, d_err_o});
    end
    inj_ack = 0; inj_err = 0;
    tick();
    d_cyc = 0; d_stb = 0;
    settle();
  endtask

  task automatic test_reset_mid();
    tick();
    d_adr = 32'h700; d_we = 1; d_cyc = 1; d_stb = 1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (grant_o !== 2'b10 || wb_cyc_o !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: grant %b cyc %b want 10 1", grant_o, wb_cyc_o);
    end
    #2 rst_n = 0;
    #1;
    n_vec++;
    if ({grant_o, wb_cyc_o, wb_stb_o, d_ack_o} !== 5'b0) begin
      n_err++; $display("FAIL rstmid_async: grant/cyc/stb/ack %b want 00000",
                        {grant_o, wb_cyc_o, wb_stb_o, d_ack_o});
    end
    d_cyc = 0; d_stb = 0;
    @(negedge clk);
    rst_n = 1;
    settle();
  endtask

  task automatic test_watchdog();
    int err_c = -1;
    tick();
    slv_en = 0;
    d_adr = 32'h800; d_we = 0; d_cyc = 1; d_stb = 1;
    @(posedge clk);
`ifdef MOXIE_ARB_WATCHDOG_EN
    for (int c = 1; c <= 20 && err_c < 0; c++) begin
      @(negedge clk);
      if (d_err_o) begin
        err_c = c;
        n_vec++;
        if ({wb_cyc_o, wb_stb_o, f_err_o} !== 3'b000) begin
          n_err++; $display("FAIL wdt_kill: cyc/stb/f_err %b want 000", {wb_cyc_o, wb_stb_o, f_err_o});
        end
      end
      tick();
    end
    n_vec++;
    if (err_c !== 8) begin
      n_err++; $display("FAIL wdt_cycle: err in stb cycle %0d want 8", err_c);
    end
    // Master keeps cyc for a few cycles after the abort; it must not be regranted.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (grant_o !== 2'b00 || d_err_o !== 1'b0) begin
        n_err++; $display("FAIL wdt_idle_%0d: grant %b err %b want 00 0", c, grant_o, d_err_o);
      end
      tick();
    end
`else
    begin
      int errs = 0;
      int lost = 0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (d_err_o || f_err_o) errs++;
        if (grant_o !== 2'b10) lost++;
      end
      n_vec++;
      if (errs !== 0) begin
        n_err++; $display("FAIL nowdt_err: %0d err cycles want 0", errs);
      end
      n_vec++;
      if (lost !== 0) begin
        n_err++; $display("FAIL nowdt_grant: %0d cycles without data grant want 0", lost);
      end
      err_c = 0;
    end
`endif
    d_cyc = 0; d_stb = 0;
    slv_en = 1;
    settle();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_fetch_read();
    test_simultaneous();
    test_starvation();
    test_fetch_burst();
    test_stray();
    test_reset_mid();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/moxie_wb_arbiter.md
# moxie_wb_arbiter

Two-master Wishbone arbiter placed between the Moxie core's instruction-fetch port and its load/store (data) port and the single external Wishbone master bus. It grants the bus to one requester at a time, holding each grant for a complete Wishbone cycle. Data accesses take priority, and a starvation counter guarantees that fetch eventually gets the bus. Acknowledges and errors are routed back only to the granted requester, and an optional watchdog aborts hung bus cycles.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while fetch waits. Range 1..15.
- `TIMEOUT`, default 255: cycles without ack/err before abort. Range 1..255. Used only with the watchdog.

Ports:
- `clk_i` in 1: clock. All state changes on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `f_cyc_i`, `f_stb_i` in 1 each: fetch cycle and strobe.
- `f_adr_i` in 32: fetch address. Fetch is read-only.
- `f_dat_o` out 32: fetch read data.
- `f_ack_o`, `f_err_o` out 1 each: fetch ack and error.
- `d_cyc_i`, `d_stb_i`, `d_we_i` in 1 each: data cycle, strobe and write enable.
- `d_sel_i` in 4: data byte selects.
- `d_adr_i`, `d_dat_i` in 32 each: data address and write data.
- `d_dat_o` out 32: data read data.
- `d_ack_o`, `d_err_o` out 1 each: data ack and error.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1 each: bus cycle, strobe and write enable.
- `wb_sel_o` out 4: bus byte selects.
- `wb_adr_o`, `wb_dat_o` out 32 each: bus address and write data.
- `wb_dat_i` in 32: bus read data.
- `wb_ack_i`, `wb_err_i` in 1 each: bus ack and error.
- `grant_o` out 2: current grant, one-hot. `2'b01` = fetch, `2'b10` = data, `2'b00` = none.

## Operation
States and their grants:
- `IDLE`: no grant.
- `GNT_F`: fetch owns the bus.
- `GNT_D`: data owns the bus.

Arbitration is evaluated in `IDLE` and on the release edge of a grant:
- If `d_cyc_i` is high and (`f_cyc_i` is low or `starve_cnt` < `STARVE_LIMIT`), grant data.
- Else if `f_cyc_i` is high, grant fetch.
- Else go to `IDLE`.

Release:
- In `GNT_X`, when `X_cyc_i` is low at a rising edge, the arbiter re-arbitrates on that same edge.
- A direct `GNT_D` to `GNT_F` handover has no idle cycle, and vice versa.

Starvation counter (`starve_cnt`, 4 bits):
- Increments, saturating, on each new data grant issued while `f_cyc_i` is high.
- Clears when fetch is granted.
- Clears when `f_cyc_i` is low in `IDLE`.

Bus muxing (combinational from the registered grant):
- Bus outputs mirror the granted master's signals. `wb_we_o` and `wb_sel_o` are forced to 0 and 4'hF under a fetch grant.
- With no grant, all `wb_*` outputs are 0.
- `wb_dat_i` is driven to both `f_dat_o` and `d_dat_o` unconditionally.
- `X_ack_o` = `wb_ack_i` AND `grant_o[X]`. `X_err_o` follows the same rule.
- The ungranted master never sees ack or err.

Reset values: state `IDLE`, `grant_o` = 0, `starve_cnt` = 0. All outputs are 0 except `f_dat_o` and `d_dat_o`, which follow `wb_dat_i`.

## Timing
- Grant latency: a request sampled at edge N gives `grant_o` and `wb_cyc_o` high after edge N. Minimum one cycle of arbitration latency from IDLE.
- Handover latency: zero idle cycles. The new master's `wb_cyc_o` is high in the cycle after the releasing master's `cyc` drops.
- Ack/err: combinational passthrough, zero added latency.
- A grant is never revoked while the owner holds `cyc`. Multi-beat (held `cyc`) cycles stay atomic.
- If `f_cyc_i` and `d_cyc_i` rise in the same cycle, data wins unless `starve_cnt` ≥ `STARVE_LIMIT`.
- Reset asserted mid-cycle: asynchronously returns to `IDLE` and drops `wb_cyc_o` and `wb_stb_o` immediately. No ack is forwarded.
- If `wb_ack_i` or `wb_err_i` arrives with no grant, it is ignored.

## Configuration
- `MOXIE_ARB_WATCHDOG_EN` defined:
  - An 8-bit counter clears on each grant edge and on each ack/err.
  - It increments each cycle with `wb_stb_o` high and neither `wb_ack_i` nor `wb_err_i`.
  - On reaching `TIMEOUT`, `X_err_o` pulses for one cycle to the owner, `wb_cyc_o` and `wb_stb_o` drop the same cycle, and the state goes to `IDLE` at the next edge.
  - The master must drop `cyc` on err. Until it does, the aborted master is not regranted.
- Not defined: no counter. `X_err_o` reflects only `wb_err_i`, and a hung slave stalls the bus indefinitely.

## Test plan
- Fetch-only read at 0x100, slave acks 2 cycles after `stb`. Expect `grant_o`=01 one cycle after `f_cyc_i`, `f_ack_o` coincident with `wb_ack_i`, `d_ack_o` = 0 throughout.
- Simultaneous fetch and data requests from `IDLE`. Expect data granted first with `wb_we_o`/`wb_sel_o`/`wb_adr_o` = `d_*`, then fetch granted on the edge `d_cyc_i` falls, with no idle cycle.
- Data re-requests back-to-back 6 times while fetch is held, `STARVE_LIMIT`=4. Expect exactly 4 data grants, then fetch granted, then `starve_cnt` = 0.
- Fetch holds `cyc` for 3 acked beats while data requests. Expect the grant to stay 01 until `f_cyc_i` drops, with data never acked early.
- `rst_ni` pulsed low mid-data-cycle. Expect `wb_cyc_o` = 0 and `grant_o` = 0 asynchronously, before the next edge.
- With `MOXIE_ARB_WATCHDOG_EN` and `TIMEOUT`=8, the slave never acks. Expect a `d_err_o` pulse in the 8th `stb` cycle, `wb_cyc_o` low in that cycle, and `IDLE` after. Without the macro, expect no err after 300 cycles.
